instr_fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode/execute pipeline of the 16-bit core. It generates word addresses to instruction memory and buffers returned instructions with their PCs in a small prefetch FIFO. It presents them to decode over a valid/ready handshake. It stops fetching at the halt opcode 16'hF000 and flags completion when that opcode is consumed.

---
 rtl/instr_fetch_queue.sv | 133 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues single outstanding word fetches and buffers
// responses with their PCs in a prefetch FIFO presented over valid/ready.
module instr_fetch_queue #(
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(16'hF000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic              halted
);

  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic              req_q, req_d, outst_q, outst_d, stale_q, stale_d;
  logic              stop_q, stop_d, halted_q, halted_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] fifo_instr_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q    [DEPTH];
  logic              pop, push, resp, issue, redir, halt_pop, flush;

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign halted    = halted_q;
  assign out_valid = (cnt_q != '0) && !halted_q;
  assign out_instr = out_valid ? fifo_instr_q[rd_q] : '0;
  assign out_pc    = out_valid ? fifo_pc_q[rd_q]    : '0;

  always_comb begin
    redir    = redirect && !halted_q;
    pop      = out_valid && out_ready;
    halt_pop = pop && (fifo_instr_q[rd_q] == HALT_INSTR);
    resp     = imem_rvalid && outst_q;
    flush    = redir || halt_pop || halted_q;
    push     = resp && !stale_q && !flush;
    issue    = !outst_q && !stop_q && !halted_q && (cnt_q < DEPTH_C) && !redirect;

    pc_d     = pc_q;
    addr_d   = addr_q;
    req_d    = issue;
    outst_d  = outst_q;
    stale_d  = stale_q;
    stop_d   = stop_q;
    halted_d = halted_q || halt_pop;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;

    if (issue) begin
      addr_d  = pc_q;
      pc_d    = pc_q + ADDR_W'(1);
      outst_d = 1'b1;
    end
    if (resp) begin
      outst_d = 1'b0;
      stale_d = 1'b0;
    end
    if (push && (imem_rdata == HALT_INSTR)) stop_d = 1'b1;

    // A response landing in the redirect cycle is dropped outright, so stale
    // only marks a request that is still in flight after this edge.
    if (redir) begin
      pc_d    = redirect_pc;
      stop_d  = 1'b0;
      stale_d = outst_q && !imem_rvalid;
    end

    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      outst_q  <= 1'b0;
      stale_q  <= 1'b0;
      stop_q   <= 1'b0;
      halted_q <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      outst_q  <= outst_d;
      stale_q  <= stale_d;
      stop_q   <= stop_d;
      halted_q <= halted_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

  // addr_q still holds the address of the single outstanding request.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_q] <= imem_rdata;
      fifo_pc_q[wr_q]    <= addr_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory responder, event logs and
// immediate-assertion checks against hand-derived expectations.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_rvalid = 1'b0;
  logic [15:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid, out_ready = 1'b0, halted;
  logic [15:0] out_instr, out_pc;

  logic        imem_req2, imem_rvalid2 = 1'b0, redirect2 = 1'b0, out_ready2 = 1'b1;
  logic [15:0] imem_addr2, imem_rdata2 = '0, redirect_pc2 = '0;
  logic        out_valid2, halted2;
  logic [15:0] out_instr2, out_pc2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned lat = 1;
  logic        halt_en = 1'b0;
  logic        spur = 1'b0;
  int unsigned pend_cnt = 0;
  logic [15:0] pend_addr = '0;
  logic        pend2 = 1'b0;
  logic [15:0] pend2_addr = '0;
  logic        found;

  logic [15:0] req_log[$];
  logic [15:0] pop_pc[$];
  logic [15:0] pop_instr[$];
  logic [15:0] req2_log[$];

  instr_fetch_queue dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .halted(halted)
  );

  instr_fetch_queue #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .redirect(redirect2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_instr(out_instr2), .out_pc(out_pc2),
    .out_ready(out_ready2), .halted(halted2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == 16'd5) return 16'hF000;
    return 16'h1000 + a;
  endfunction

  // Memory model: response strobe lat cycles after the request cycle.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (rst) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt != 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end
      end
      if (spur) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hBEEF;
      end
      if (imem_req) begin
        pend_cnt  = lat;
        pend_addr = imem_addr;
      end
    end
  end

  always @(negedge clk) begin
    imem_rvalid2 = rst ? 1'b0 : pend2;
    if (pend2) imem_rdata2 = 16'h1000 + pend2_addr;
    pend2      = !rst && imem_req2;
    pend2_addr = imem_addr2;
  end

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (imem_req) req_log.push_back(imem_addr);
      if (imem_req2) req2_log.push_back(imem_addr2);
      if (out_valid && out_ready) begin
        pop_pc.push_back(out_pc);
        pop_instr.push_back(out_instr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int unsigned lat_v, input logic ready_v, input logic halt_v);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_halted", halted, 0);
    check("rst_async_req", imem_req, 0);
    redirect  = 1'b0;
    spur      = 1'b0;
    lat       = lat_v;
    out_ready = ready_v;
    halt_en   = halt_v;
    req_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    req2_log.delete();
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(1);
    check("reset_req", imem_req, 0);
    check("reset_addr", imem_addr, 16'h0000);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_instr", out_instr, 0);
    check("reset_out_pc", out_pc, 0);
    check("reset_halted", halted, 0);
    check("reset_addr_dut2", imem_addr2, 16'hFFFE);

    // Streaming with ready high
    out_ready = 1'b1;
    lat = 1;
    rst = 1'b0;
    tick(1);
    check("first_req_after_release", imem_req, 1);
    check("first_req_addr", imem_addr, 16'h0000);
    tick(30);
    for (int i = 0; i < 4; i++) check("stream_req_addr", req_log[i], i);
    for (int i = 0; i < 3; i++) begin
      check("stream_pop_pc", pop_pc[i], i);
      check("stream_pop_instr", pop_instr[i], 16'h1000 + i);
    end
    check("stream_halted", halted, 0);
    check("wrap_req0", req2_log[0], 16'hFFFE);
    check("wrap_req1", req2_log[1], 16'hFFFF);
    check("wrap_req2", req2_log[2], 16'h0000);

    // Backpressure fills exactly DEPTH entries
    do_reset(1, 1'b0, 1'b0);
    tick(20);
    check("bp_req_count", req_log.size(), 4);
    check("bp_req_last", req_log[3], 3);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_pc", out_pc, 0);
    check("bp_head_instr", out_instr, 16'h1000);
    check("bp_no_req", imem_req, 0);
    out_ready = 1'b1;
    tick(4);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) check("bp_pop_pc", pop_pc[i], i);
    check("bp_pop_count", pop_pc.size(), 4);
    tick(10);
    check("bp_resume_addr", req_log[4], 4);
    check("bp_resume_head_pc", out_pc, 4);
    check("bp_resume_head_instr", out_instr, 16'h1004);

    // Redirect with a request in flight
    do_reset(3, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (imem_req && imem_addr == 16'd2) found = 1'b1;
    end
    check("redir_found_addr2", found, 1);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick(1);
    redirect = 1'b0;
    req_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    check("redir_flushed", out_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(1);
      if (imem_req) found = 1'b1;
    end
    check("redir_req_seen", found, 1);
    check("redir_req_addr", imem_addr, 16'h0040);
    tick(20);
    check("redir_first_pop_pc", pop_pc[0], 16'h0040);
    check("redir_first_pop_instr", pop_instr[0], 16'h1040);

    // Halt opcode at address 5
    do_reset(1, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (out_valid && out_pc == 16'd5) found = 1'b1;
    end
    check("halt_entry_seen", found, 1);
    check("halt_entry_instr", out_instr, 16'hF000);
    check("halt_not_yet", halted, 0);
    tick(1);
    check("halt_set", halted, 1);
    check("halt_out_valid", out_valid, 0);
    tick(10);
    check("halt_req_count", req_log.size(), 6);
    check("halt_req_last", req_log[5], 5);
    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    tick(1);
    redirect = 1'b0;
    tick(10);
    check("halt_redir_req_count", req_log.size(), 6);
    check("halt_redir_halted", halted, 1);
    check("halt_redir_out_valid", out_valid, 0);

    // Redirect coincident with rvalid, then a spurious rvalid
    do_reset(1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (imem_req && imem_addr == 16'd2) found = 1'b1;
    end
    check("coinc_found_addr2", found, 1);
    tick(1);
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    tick(1);
    redirect = 1'b0;
    req_log.delete();
    pop_pc.delete();
    pop_instr.delete();
    check("coinc_flushed", out_valid, 0);
    check("coinc_no_req", imem_req, 0);
    tick(1);
    check("coinc_req", imem_req, 1);
    check("coinc_req_addr", imem_addr, 16'h0080);
    tick(20);
    check("coinc_head_pc", out_pc, 16'h0080);
    check("coinc_head_instr", out_instr, 16'h1080);
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(5);
    check("spur_req_count", req_log.size(), 4);
    check("spur_head_pc", out_pc, 16'h0080);
    out_ready = 1'b1;
    tick(4);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("spur_pop_pc", pop_pc[i], 16'h0080 + i);
      check("spur_pop_instr", pop_instr[i], 16'h1080 + i);
    end
    tick(3);
    check("pre_rst_out_valid", out_valid, 1);
    do_reset(1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
